// File: rtl/tlul_host_adapter_if.sv
// Bus bundle for tlul_host_adapter: simple request/response port plus TL-UL A/D channels.
// master is the adapter's view; slave is the view of whatever sits on the other side.
interface tlul_host_adapter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_bits_opcode;
  logic [2:0]  a_bits_param;
  logic [1:0]  a_bits_size;
  logic [7:0]  a_bits_source;
  logic [31:0] a_bits_address;
  logic [3:0]  a_bits_mask;
  logic [31:0] a_bits_data;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_bits_opcode;
  logic [2:0]  d_bits_param;
  logic [1:0]  d_bits_size;
  logic [7:0]  d_bits_source;
  logic        d_bits_sink;
  logic [31:0] d_bits_data;
  logic        d_bits_denied;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size,
    input  d_bits_source, d_bits_sink, d_bits_data, d_bits_denied,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
    output a_bits_address, a_bits_mask, a_bits_data, d_ready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size,
    output d_bits_source, d_bits_sink, d_bits_data, d_bits_denied,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
    input  a_bits_address, a_bits_mask, a_bits_data, d_ready
  );
endinterface

// File: rtl/tlul_host_adapter.sv
// Single-outstanding TL-UL host adapter: turns a req/rsp handshake into Get/Put A beats,
// checks the D response, and reports misalignment, denial and local timeouts.
module tlul_host_adapter #(
  parameter logic [7:0]  SOURCE_ID      = 8'h00,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  tlul_host_adapter_if.master    bus,
  output logic                   stray_o
);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_REQ  = 2'd1,
    D_WAIT = 2'd2,
    RSP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic [15:0] tmo_cnt;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        rsp_timeout_q;
  logic        stray_q;

  logic        misaligned;
  logic        d_accept;
  logic        d_err;
  logic        tmo_expired;
  logic        unused_d;

  assign unused_d    = ^{bus.d_bits_param, bus.d_bits_size, bus.d_bits_sink};
  assign misaligned  = (bus.req_addr[1:0] != 2'b00);
  assign d_accept    = bus.d_valid && bus.d_ready;
  assign tmo_expired = (tmo_cnt == (TIMEOUT_CYCLES - 16'd1));
  assign d_err       = bus.d_bits_denied ||
                       (bus.d_bits_source != SOURCE_ID) ||
                       (bus.d_bits_opcode != (cap_we ? OP_ACK : OP_ACK_DATA));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cap_we        <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_be        <= '0;
      tmo_cnt       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      // d_ready stays high before the A handshake, so beats there are swallowed as strays
      if (d_accept && (state_q == IDLE || state_q == A_REQ)) begin
        stray_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            cap_we    <= bus.req_we;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_be    <= bus.req_be;
            tmo_cnt   <= '0;
            if (misaligned) begin
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_rdata_q   <= '0;
            end
          end
        end
        D_WAIT: begin
          // a response arriving on the expiry cycle takes priority over the timeout
          if (bus.d_valid) begin
            rsp_err_q     <= d_err;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= (!d_err && !cap_we) ? bus.d_bits_data : '0;
          end else if (tmo_expired) begin
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.req_valid) state_d = misaligned ? RSP : A_REQ;
      A_REQ:  if (bus.a_ready) state_d = D_WAIT;
      D_WAIT: if (bus.d_valid || tmo_expired) state_d = RSP;
      RSP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready      = rst_ni && (state_q == IDLE);
  assign bus.d_ready        = rst_ni && (state_q != RSP);
  assign bus.a_valid        = (state_q == A_REQ);
  assign bus.a_bits_opcode  = !cap_we ? OP_GET : ((cap_be == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL);
  assign bus.a_bits_param   = 3'd0;
  assign bus.a_bits_size    = 2'd2;
  assign bus.a_bits_source  = SOURCE_ID;
  assign bus.a_bits_address = cap_addr;
  assign bus.a_bits_mask    = cap_we ? cap_be : 4'hF;
  assign bus.a_bits_data    = cap_we ? cap_wdata : '0;

  assign bus.rsp_valid      = (state_q == RSP);
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.rsp_timeout    = rsp_timeout_q;
  assign stray_o            = stray_q;

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Bench for tlul_host_adapter: vector table for single transactions, hand sequences for
// A-channel stall, response backpressure, timeout, timeout race, strays and mid-flight reset.
module tb_tlul_host_adapter;

  logic clk;
  logic rst_ni;
  logic stray_o;

  tlul_host_adapter_if bus ();

  tlul_host_adapter #(
    .SOURCE_ID      (8'h00),
    .TIMEOUT_CYCLES (16'd4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .bus     (bus.master),
    .stray_o (stray_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  d_op;
    logic [7:0]  d_src;
    logic        d_den;
    logic [31:0] d_data;
    logic [2:0]  e_op;
    logic [3:0]  e_mask;
    logic [31:0] e_data;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic        tmo;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic push_exp(input logic err, input logic tmo, input logic [31:0] rdata);
    exp_t e;
    e.err = err; e.tmo = tmo; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [7:0] src, input logic den,
                         input logic [31:0] data);
    bus.d_valid       = 1'b1;
    bus.d_bits_opcode = op;
    bus.d_bits_source = src;
    bus.d_bits_denied = den;
    bus.d_bits_data   = data;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
  endtask

  task automatic drain_rsp(input string name);
    exp_t e;
    for (int n = 0; n < 20 && !bus.rsp_valid; n++) tick();
    check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_err"},   32'(bus.rsp_err),     32'(e.err));
      check({name, "_tmo"},   32'(bus.rsp_timeout), 32'(e.tmo));
      check({name, "_rdata"}, bus.rsp_rdata,        e.rdata);
    end else begin
      check({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({name, "_rsp_done"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    drive_req(v.we, v.addr, v.wdata, v.be);
    check({p, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    push_exp(v.e_err, 1'b0, v.e_rdata);
    tick();
    bus.req_valid = 1'b0;
    if (v.addr[1:0] != 2'b00) begin
      check({p, "_no_a"},  32'(bus.a_valid),   32'd0);
      check({p, "_early"}, 32'(bus.rsp_valid), 32'd1);
    end else begin
      check({p, "_a_valid"}, 32'(bus.a_valid),        32'd1);
      check({p, "_op"},      32'(bus.a_bits_opcode),  32'(v.e_op));
      check({p, "_mask"},    32'(bus.a_bits_mask),    32'(v.e_mask));
      check({p, "_data"},    bus.a_bits_data,         v.e_data);
      check({p, "_addr"},    bus.a_bits_address,      v.addr);
      check({p, "_szprm"},   32'({bus.a_bits_size, bus.a_bits_param, bus.a_bits_source}),
            32'({2'd2, 3'd0, 8'h00}));
      tick();
      check({p, "_a_drop"}, 32'(bus.a_valid), 32'd0);
      drive_d(v.d_op, v.d_src, v.d_den, v.d_data);
      tick();
      bus.d_valid = 1'b0;
      check({p, "_lat3"}, 32'(bus.rsp_valid), 32'd1);
    end
    drain_rsp(p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    //          we    addr          wdata         be    d_op  d_src  den   d_data        e_op  mask  e_data        err   e_rdata
    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0,        4'hF, 3'd1, 8'h00, 1'b0, 32'hDEADBEEF, 3'd4, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h0000_1004, 32'h0000_1234, 4'h3, 3'd0, 8'h00, 1'b0, 32'h0,        3'd1, 4'h3, 32'h0000_1234, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_1008, 32'hCAFEF00D, 4'hF, 3'd0, 8'h00, 1'b0, 32'h0,        3'd0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_100C, 32'h0,        4'hF, 3'd1, 8'h00, 1'b1, 32'h5555_5555, 3'd4, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_1010, 32'h0,        4'hF, 3'd1, 8'h05, 1'b0, 32'h1111_2222, 3'd4, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_1014, 32'h0,        4'hF, 3'd0, 8'h00, 1'b0, 32'h3333_4444, 3'd4, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_1018, 32'h0000_00AA, 4'h1, 3'd1, 8'h00, 1'b0, 32'h7777_7777, 3'd1, 4'h1, 32'h0000_00AA, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_1002, 32'h0,        4'hF, 3'd1, 8'h00, 1'b0, 32'h0,        3'd4, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[8] = '{1'b1, 32'h0000_1001, 32'hFFFF_FFFF, 4'hF, 3'd0, 8'h00, 1'b0, 32'h0,        3'd0, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[9] = '{1'b0, 32'h0000_0020, 32'h9999_9999, 4'h5, 3'd1, 8'h00, 1'b0, 32'h0BAD_F00D, 3'd4, 4'hF, 32'h0,        1'b0, 32'h0BAD_F00D};

    rst_ni            = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.req_be        = '0;
    bus.rsp_ready     = 1'b0;
    bus.a_ready       = 1'b1;
    bus.d_valid       = 1'b0;
    bus.d_bits_opcode = '0;
    bus.d_bits_param  = '0;
    bus.d_bits_size   = 2'd2;
    bus.d_bits_source = '0;
    bus.d_bits_sink   = 1'b0;
    bus.d_bits_data   = '0;
    bus.d_bits_denied = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_d_ready",   32'(bus.d_ready),   32'd0);
    check("rst_outputs",   32'({bus.a_valid, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, stray_o}), 32'd0);
    check("rst_rdata",     bus.rsp_rdata, 32'h0);
    rst_ni = 1'b1;
    tick();
    check("idle_ready", 32'({bus.req_ready, bus.d_ready}), 32'b11);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // A channel held off for five cycles, then response backpressure for three
    bus.a_ready = 1'b0;
    drive_req(1'b0, 32'h0000_2000, 32'h0, 4'hF);
    push_exp(1'b0, 1'b0, 32'h1122_3344);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_a", i), 32'({bus.a_valid, bus.a_bits_opcode, bus.a_bits_mask}),
            32'({1'b1, 3'd4, 4'hF}));
      check($sformatf("stall%0d_addr", i), bus.a_bits_address, 32'h0000_2000);
      tick();
    end
    bus.a_ready = 1'b1;
    tick();
    check("stall_dwait", 32'({bus.a_valid, bus.d_ready}), 32'b01);
    drive_d(3'd1, 8'h00, 1'b0, 32'h1122_3344);
    tick();
    bus.d_valid = 1'b0;
    held = bus.rsp_rdata;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_hold", i), 32'({bus.rsp_valid, bus.d_ready, bus.rsp_err}), 32'b100);
      check($sformatf("bp%0d_rdata", i), bus.rsp_rdata, 32'h1122_3344);
      tick();
    end
    check("bp_rdata_stable", bus.rsp_rdata, held);
    drain_rsp("stall");

    // no D response: timeout four cycles after the A handshake
    drive_req(1'b0, 32'h0000_3000, 32'h0, 4'hF);
    push_exp(1'b1, 1'b1, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("tmo_wait%0d", i), 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    check("tmo_at4", 32'(bus.rsp_valid), 32'd1);
    drain_rsp("tmo");
    check("stray_before", 32'(stray_o), 32'd0);
    drive_d(3'd1, 8'h00, 1'b0, 32'h0);
    tick();
    bus.d_valid = 1'b0;
    check("stray_after", 32'(stray_o), 32'd1);
    tick();
    check("stray_sticky", 32'(stray_o), 32'd1);

    // D beat on the expiry cycle wins over the timeout
    drive_req(1'b0, 32'h0000_4000, 32'h0, 4'hF);
    push_exp(1'b0, 1'b0, 32'hA5A5_A5A5);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("race_no_rsp", 32'(bus.rsp_valid), 32'd0);
    drive_d(3'd1, 8'h00, 1'b0, 32'hA5A5_A5A5);
    tick();
    bus.d_valid = 1'b0;
    drain_rsp("race");

    // reset while waiting for D abandons the transaction
    drive_req(1'b0, 32'h0000_5000, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    check("midrst_ready", 32'({bus.req_ready, bus.d_ready}), 32'b00);
    tick();
    check("midrst_out", 32'({bus.a_valid, bus.rsp_valid, stray_o}), 32'b000);
    rst_ni = 1'b1;
    tick();
    check("midrst_idle", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
    drive_d(3'd1, 8'h00, 1'b0, 32'hFEED_FACE);
    tick();
    bus.d_valid = 1'b0;
    check("midrst_stray", 32'({stray_o, bus.rsp_valid}), 32'b10);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
